pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
- Parametrised pipeline-stage register, successor to the fixed-field stage registers between core pipeline stages.
- Carries a packed payload of DATA_W bits with valid/ready handshaking on both sides.
- Has an internal 2-entry skid (main + skid) so up_ready_o is a registered signal.
- Supports flush (kill all in-flight entries) and stall (freeze downstream transfer); used between ID/EXE/MEM when any stage may back-pressure.

Parameters:
DATA_W, 32, payload width in bits (>=1)
RESET_VAL, 0, value loaded into both data registers on reset and flush
CNT_W, 16, width of the stall performance counter

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  asynchronous, active-high reset
flush_i  input  1  kill all held entries; same-cycle upstream beat discarded
stall_i  input  1  freeze downstream side; acts as dn_ready_i forced low
up_valid_i  input  1  upstream payload valid
up_ready_o  output  1  block can accept; registered, equals !skid_valid
up_data_i  input  DATA_W  upstream payload
dn_valid_o  output  1  main entry valid
dn_ready_i  input  1  downstream can accept
dn_data_o  output  DATA_W  main entry payload
occupancy_o  output  2  number of valid entries, 0..2
stall_cnt_o  output  CNT_W  stall-cycle counter (see Optional Feature)

Behaviour:
- State: main_valid/main_data, skid_valid/skid_data.
- dn_valid_o = main_valid; dn_data_o = main_data; up_ready_o = !skid_valid; occupancy_o = main_valid + skid_valid.
- Handshakes:
  - up_fire = up_valid_i & up_ready_o & !flush_i.
  - dn_fire = main_valid & dn_ready_i & !stall_i & !flush_i.
- Reset (async, rst_i=1): main_valid=0, skid_valid=0, both data regs = RESET_VAL, up_ready_o=1, occupancy_o=0, stall_cnt_o=0. Takes effect immediately and overrides any transfer in progress.
- Flush (sync, priority over stall and all fires): next cycle both valids=0 and both data regs=RESET_VAL. The up_data_i beat presented in the flush cycle is dropped. up_ready_o=1 on the following cycle. stall_cnt_o is not cleared.
- Update rules, evaluated when not flushing:
  - main empty, up_fire: main <= up_data_i. Latency is 1 cycle.
  - main valid, dn_fire, skid empty: main <= up_data_i if up_fire, else main_valid <= 0.
  - main valid, no dn_fire, skid empty, up_fire: skid <= up_data_i; up_ready_o drops next cycle.
  - skid valid, dn_fire: main <= skid; skid_valid <= 0. No upstream accept this cycle because up_ready_o=0.
  - skid valid, no dn_fire: all state held.
- stall_i holds main and skid contents exactly. Upstream may still fill an empty skid during stall.
- Stability: while dn_valid_o=1 and no dn_fire, dn_data_o is unchanged cycle to cycle. When main is empty, dn_data_o holds its last value (or RESET_VAL after reset/flush).
- Ordering: beats leave strictly in acceptance order; no beat is duplicated or lost except on flush.
- Throughput: 1 beat/cycle when dn_ready_i=1 and stall_i=0.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined: stall_cnt_o increments by 1 each cycle with dn_valid_o=1 and no dn_fire. It saturates at all-ones (no wrap), is cleared only by rst_i, and is unaffected by flush_i.
- Undefined: the port remains, stall_cnt_o is tied to 0, and no counter logic is generated.

Test Plan:
- Reset mid-operation: skid full (occupancy 2), assert rst_i between clock edges -> dn_valid_o=0, up_ready_o=1, occupancy_o=0, dn_data_o=RESET_VAL immediately, without waiting for a clock edge.
- Streaming: 8 beats 0x11..0x88 with up_valid_i=1 and dn_ready_i=1 -> outputs 0x11..0x88 in order, one per cycle, first beat 1 cycle after its accept, occupancy_o never exceeds 1.
- Backpressure skid: dn_ready_i=0, send 0xA1 then 0xA2 -> occupancy_o=2, up_ready_o=0, dn_data_o=0xA1 held. Raise dn_ready_i -> 0xA1 then 0xA2 delivered, up_ready_o=1 after the first drain.
- Stall: main=0x55 valid, dn_ready_i=1, stall_i=1 for 3 cycles -> no dn_fire, dn_data_o=0x55 stable. With PIPE_STAGE_PERF_EN, stall_cnt_o increments by 3.
- Flush priority: occupancy 2 (0xB1, 0xB2), assert flush_i, stall_i and up_valid_i (0xB3) together -> next cycle occupancy_o=0, dn_valid_o=0, dn_data_o=RESET_VAL, 0xB3 never appears.
- Counter saturation: CNT_W=4, PIPE_STAGE_PERF_EN defined, 20 blocked cycles -> stall_cnt_o=15 and it holds at 15.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with a 2-entry (main + skid) buffer so up_ready_o comes straight from a flop.
// Optional stall performance counter is built only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_buf #(
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [DATA_W-1:0] up_data_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [DATA_W-1:0] dn_data_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic              main_valid, skid_valid;
    logic [DATA_W-1:0] main_data, skid_data;
    logic              up_fire, dn_fire;

    assign up_ready_o  = !skid_valid;
    assign dn_valid_o  = main_valid;
    assign dn_data_o   = main_data;
    assign occupancy_o = {1'b0, main_valid} + {1'b0, skid_valid};

    // stall_i behaves as a forced-low dn_ready_i; flush suppresses both sides
    assign up_fire = up_valid_i & !skid_valid & !flush_i;
    assign dn_fire = main_valid & dn_ready_i & !stall_i & !flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= RESET_VAL;
            skid_data  <= RESET_VAL;
        end else if (flush_i) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= RESET_VAL;
            skid_data  <= RESET_VAL;
        end else if (!main_valid) begin
            // skid is never occupied while main is empty
            if (up_fire) begin
                main_valid <= 1'b1;
                main_data  <= up_data_i;
            end
        end else if (!skid_valid) begin
            if (dn_fire) begin
                if (up_fire) main_data  <= up_data_i;
                else         main_valid <= 1'b0;
            end else if (up_fire) begin
                skid_valid <= 1'b1;
                skid_data  <= up_data_i;
            end
        end else if (dn_fire) begin
            main_data  <= skid_data;
            skid_valid <= 1'b0;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt;

    // saturating; only rst_i clears it, flush has no effect
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            stall_cnt <= '0;
        else if (main_valid && !dn_fire && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed table-driven bench for pipe_stage_buf (DATA_W=8, RESET_VAL=0x5A, CNT_W=4).
module tb_pipe_stage_buf;

    localparam int          DW   = 8;
    localparam logic [7:0]  RV   = 8'h5A;
    localparam int          CW   = 4;
    localparam int          NVEC = 30;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0, stall = 1'b0, up_valid = 1'b0, dn_ready = 1'b0;
    logic [DW-1:0] up_data = '0;
    logic          up_ready, dn_valid;
    logic [DW-1:0] dn_data;
    logic [1:0]    occ;
    logic [CW-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    pipe_stage_buf #(.DATA_W(DW), .RESET_VAL(RV), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .stall_i(stall),
        .up_valid_i(up_valid), .up_ready_o(up_ready), .up_data_i(up_data),
        .dn_valid_o(dn_valid), .dn_ready_i(dn_ready), .dn_data_o(dn_data),
        .occupancy_o(occ), .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          f, s, uv;
        logic [DW-1:0] ud;
        logic          dr;
        logic          dv;
        logic [DW-1:0] dd;
        logic          ur;
        logic [1:0]    occ;
    } vec_t;

    vec_t         tbl [NVEC];
    logic         prev_dv;
    logic [CW-1:0] exp_cnt;

    function automatic vec_t mk(logic f, logic s, logic uv, logic [DW-1:0] ud, logic dr,
                                logic dv, logic [DW-1:0] dd, logic ur, logic [1:0] o);
        vec_t v;
        v.f = f; v.s = s; v.uv = uv; v.ud = ud; v.dr = dr;
        v.dv = dv; v.dd = dd; v.ur = ur; v.occ = o;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at negedge, check registered outputs just after the posedge.
    task automatic apply(vec_t v, string tag);
        @(negedge clk);
        flush = v.f; stall = v.s; up_valid = v.uv; up_data = v.ud; dn_ready = v.dr;
`ifdef PIPE_STAGE_PERF_EN
        if (prev_dv && !(v.dr && !v.s && !v.f) && exp_cnt != {CW{1'b1}})
            exp_cnt = exp_cnt + 1'b1;
`endif
        @(posedge clk);
        #1;
        chk({tag, ".dn_valid"}, 32'(dn_valid), 32'(v.dv));
        chk({tag, ".dn_data"},  32'(dn_data),  32'(v.dd));
        chk({tag, ".up_ready"}, 32'(up_ready), 32'(v.ur));
        chk({tag, ".occ"},      32'(occ),      32'(v.occ));
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_cnt));
        prev_dv = v.dv;
    endtask

    initial begin
        // streaming 0x11..0x88, one beat per cycle
        for (int i = 0; i < 8; i++)
            tbl[i] = mk(0, 0, 1, 8'(8'h11 * (i + 1)), 1, 1, 8'(8'h11 * (i + 1)), 1, 1);
        tbl[8]  = mk(0, 0, 0, 8'h00, 1, 0, 8'h88, 1, 0);
        // backpressure fills skid, then drains in order
        tbl[9]  = mk(0, 0, 1, 8'hA1, 0, 1, 8'hA1, 1, 1);
        tbl[10] = mk(0, 0, 1, 8'hA2, 0, 1, 8'hA1, 0, 2);
        tbl[11] = mk(0, 0, 1, 8'hA3, 0, 1, 8'hA1, 0, 2);
        tbl[12] = mk(0, 0, 0, 8'h00, 1, 1, 8'hA2, 1, 1);
        tbl[13] = mk(0, 0, 0, 8'h00, 1, 0, 8'hA2, 1, 0);
        // stall holds main for 3 cycles despite dn_ready
        tbl[14] = mk(0, 0, 1, 8'h55, 0, 1, 8'h55, 1, 1);
        tbl[15] = mk(0, 1, 0, 8'h00, 1, 1, 8'h55, 1, 1);
        tbl[16] = mk(0, 1, 0, 8'h00, 1, 1, 8'h55, 1, 1);
        tbl[17] = mk(0, 1, 0, 8'h00, 1, 1, 8'h55, 1, 1);
        tbl[18] = mk(0, 0, 0, 8'h00, 1, 0, 8'h55, 1, 0);
        // upstream fills skid during stall; 0x99 refused while skid full
        tbl[19] = mk(0, 0, 1, 8'h66, 1, 1, 8'h66, 1, 1);
        tbl[20] = mk(0, 1, 1, 8'h77, 1, 1, 8'h66, 0, 2);
        tbl[21] = mk(0, 0, 1, 8'h99, 1, 1, 8'h77, 1, 1);
        tbl[22] = mk(0, 0, 0, 8'h00, 1, 0, 8'h77, 1, 0);
        // flush beats stall and the same-cycle upstream beat
        tbl[23] = mk(0, 0, 1, 8'hB1, 0, 1, 8'hB1, 1, 1);
        tbl[24] = mk(0, 0, 1, 8'hB2, 0, 1, 8'hB1, 0, 2);
        tbl[25] = mk(1, 1, 1, 8'hB3, 1, 0, RV,    1, 0);
        tbl[26] = mk(0, 0, 0, 8'h00, 1, 0, RV,    1, 0);
        tbl[27] = mk(1, 0, 1, 8'hC1, 0, 0, RV,    1, 0);
        tbl[28] = mk(0, 0, 1, 8'hC2, 0, 1, 8'hC2, 1, 1);
        tbl[29] = mk(1, 0, 0, 8'h00, 0, 0, RV,    1, 0);

        prev_dv = 1'b0;
        exp_cnt = '0;

        // reset state
        #12;
        chk("rst.dn_valid", 32'(dn_valid), 0);
        chk("rst.up_ready", 32'(up_ready), 1);
        chk("rst.occ",      32'(occ), 0);
        chk("rst.dn_data",  32'(dn_data), 32'(RV));
        chk("rst.stall_cnt", 32'(stall_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++)
            apply(tbl[i], $sformatf("v%0d", i));

        // long block: counter saturates at 15 when enabled, stays 0 otherwise
        apply(mk(0, 0, 1, 8'hD1, 0, 1, 8'hD1, 1, 1), "sat.load");
        for (int i = 0; i < 20; i++)
            apply(mk(0, 0, 0, 8'h00, 0, 1, 8'hD1, 1, 1), $sformatf("sat%0d", i));
        apply(mk(0, 0, 1, 8'hD2, 0, 1, 8'hD1, 0, 2), "sat.skid");

        // async reset mid-cycle with skid full: outputs change without a clock edge
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mrst.dn_valid", 32'(dn_valid), 0);
        chk("mrst.up_ready", 32'(up_ready), 1);
        chk("mrst.occ",      32'(occ), 0);
        chk("mrst.dn_data",  32'(dn_data), 32'(RV));
        chk("mrst.stall_cnt", 32'(stall_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        prev_dv = 1'b0;
        exp_cnt = '0;
        apply(mk(0, 0, 1, 8'hE1, 1, 1, 8'hE1, 1, 1), "post.load");
        apply(mk(0, 0, 0, 8'h00, 1, 0, 8'hE1, 1, 0), "post.drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
